// File: rtl/relu_act_pipe.sv
// Two-stage pipelined activation for the CNN datapath: bypass / ReLU / leaky ReLU / clamped ReLU
// on LANES signed words per beat, valid/ready with full backpressure, saturating zero-lane counter.
module relu_act_pipe #(
    parameter int DATA_W     = 20,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 255,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DATA_W-1:0]  out_data,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         zero_cnt
);

    localparam int ZW = $clog2(LANES + 1);

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_LEAKY  = 2'd2;
    localparam logic [1:0] MODE_CLAMP  = 2'd3;

    localparam logic signed [DATA_W-1:0] CLAMP_VAL = DATA_W'(CLAMP_MAX);
    localparam logic [CNT_W:0]           CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

    logic                     s1_valid_q;
    logic [LANES*DATA_W-1:0]  s1_data_q;
    logic [1:0]               s1_mode_q;
    logic                     out_valid_q;
    logic [LANES*DATA_W-1:0]  out_data_q;
    logic [CNT_W-1:0]         zero_cnt_q;

    logic                     en1;
    logic                     en2;
    logic                     out_hs;
    logic [LANES*DATA_W-1:0]  act_d;
    logic [ZW-1:0]            zeros;
    logic [CNT_W:0]           cnt_sum;
    logic [CNT_W-1:0]         zero_cnt_d;

    // S1 may advance whenever S2 is empty or draining this cycle.
    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;
    assign out_hs   = out_valid_q && out_ready;

    function automatic logic signed [DATA_W-1:0] act_fn(input logic signed [DATA_W-1:0] x,
                                                        input logic [1:0] mode);
        logic signed [DATA_W-1:0] r;
        r = x;
        case (mode)
            MODE_BYPASS: r = x;
            MODE_RELU:   r = (x > 0) ? x : '0;
            // Arithmetic shift of a negative value stays negative and in range, even at the minimum.
            MODE_LEAKY:  r = (x > 0) ? x : (x >>> LEAK_SHIFT);
            MODE_CLAMP:  r = (x <= 0) ? '0 : ((x > CLAMP_VAL) ? CLAMP_VAL : x);
            default:     r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        act_d = '0;
        for (int i = 0; i < LANES; i++) begin
            act_d[i*DATA_W +: DATA_W] = act_fn(s1_data_q[i*DATA_W +: DATA_W], s1_mode_q);
        end
    end

    always_comb begin
        zeros = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_data_q[i*DATA_W +: DATA_W] == '0) begin
                zeros = zeros + ZW'(1);
            end
        end
    end

    always_comb begin
        cnt_sum    = {1'b0, zero_cnt_q} + (CNT_W+1)'(zeros);
        zero_cnt_d = zero_cnt_q;
        if (cnt_clr) begin
            zero_cnt_d = out_hs ? CNT_W'(zeros) : '0;
        end else if (out_hs) begin
            zero_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= '0;
        end else if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_mode_q <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en2) begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= act_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign zero_cnt  = zero_cnt_q;

endmodule

// File: tb/tb_relu_act_pipe.sv
// Directed bench for relu_act_pipe (4 lanes x 20 bits, 4-bit zero counter for quick saturation).
module tb_relu_act_pipe;

    localparam int DW = 20;
    localparam int NL = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [NL*DW-1:0]  in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [NL*DW-1:0]  out_data;
    logic              cnt_clr;
    logic [CW-1:0]     zero_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    relu_act_pipe #(.DATA_W(DW), .LANES(NL), .LEAK_SHIFT(3), .CLAMP_MAX(255), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [NL*DW-1:0] pack(input int a, input int b, input int c, input int d);
        logic [DW-1:0] l0, l1, l2, l3;
        l0 = a[DW-1:0]; l1 = b[DW-1:0]; l2 = c[DW-1:0]; l3 = d[DW-1:0];
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [NL*DW-1:0] obs, input logic [NL*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_ready high; checks output, then counter after the handshake.
    task automatic send_one(input string tag, input logic [NL*DW-1:0] d, input logic [1:0] m,
                            input logic [NL*DW-1:0] exp, input int exp_cnt);
        in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 80'(out_valid), 80'(0));
        tick();
        chk({tag, "_valid"}, 80'(out_valid), 80'(1));
        chk({tag, "_data"}, out_data, exp);
        tick();
        chk({tag, "_cnt"}, 80'(zero_cnt), 80'(exp_cnt));
        chk({tag, "_drain"}, 80'(out_valid), 80'(0));
    endtask

    logic [NL*DW-1:0] bp_vec [8];
    logic [NL*DW-1:0] sw_exp [4];

    initial begin
        int sent, recv;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_zero_cnt", 80'(zero_cnt), 80'(0));
        reset_n = 1'b1;
        tick();
        chk("rst_in_ready", 80'(in_ready), 80'(1));

        send_one("relu", pack(-3, 0, 7, -524288), 2'd1, pack(0, 0, 7, 0), 3);
        send_one("leaky", pack(-5, -8, -64, 9), 2'd2, pack(-1, -1, -8, 9), 3);
        send_one("clamp", pack(300, -1, 255, 100), 2'd3, pack(255, 0, 255, 100), 4);
        send_one("leaky_min", pack(-524288, -1, 1, -7), 2'd2, pack(-65536, -1, 1, -1), 4);
        send_one("bypass_min", pack(-524288, 0, 5, -1), 2'd0, pack(-524288, 0, 5, -1), 5);
        send_one("clamp_min", pack(-524288, 256, 254, 524287), 2'd3, pack(0, 255, 254, 255), 6);

        // Per-beat mode sweep 0..3 on all lanes = -16.
        sw_exp[0] = pack(-16, -16, -16, -16);
        sw_exp[1] = '0;
        sw_exp[2] = pack(-2, -2, -2, -2);
        sw_exp[3] = '0;
        out_ready = 1'b1;
        in_data = pack(-16, -16, -16, -16);
        for (int k = 0; k < 4; k++) begin
            in_mode = 2'(k); in_valid = 1'b1;
            tick();
            if (k >= 1) chk($sformatf("sweep_%0d", k - 1), out_data, sw_exp[k - 1]);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_3", out_data, sw_exp[3]);
        tick();
        chk("sweep_cnt", 80'(zero_cnt), 80'(14));

        // Eight back-to-back bypass beats with out_ready low in cycles 3..5.
        for (int b = 0; b < 8; b++) bp_vec[b] = pack(b*10 + 1, b*10 + 2, b*10 + 3, b*10 + 4);
        sent = 0; recv = 0; in_mode = 2'd0;
        for (int c = 0; c < 30; c++) begin
            logic fire_in, fire_out;
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            in_data   = (sent < 8) ? bp_vec[sent] : '0;
            #1;
            if (c >= 3 && c <= 5) chk($sformatf("bp_in_ready_c%0d", c), 80'(in_ready), 80'(0));
            if (out_valid) begin
                if (recv < 8) chk($sformatf("bp_out_%0d", recv), out_data, bp_vec[recv]);
                else chk("bp_dup_beat", 80'(recv), 80'(8));
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            tick();
            if (fire_in) sent++;
            if (fire_out) recv++;
        end
        in_valid = 1'b0;
        chk("bp_recv_total", 80'(recv), 80'(8));
        chk("bp_cnt_unchanged", 80'(zero_cnt), 80'(14));

        // Clear alone, then saturate with five all-zero beats.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_alone", 80'(zero_cnt), 80'(0));
        out_ready = 1'b1; in_data = '0; in_mode = 2'd0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sat_cnt", 80'(zero_cnt), 80'(15));

        // Clear coinciding with a 4-zero handshake leaves exactly 4.
        out_ready = 1'b0; in_valid = 1'b1; in_data = '0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clrhs_hold_cnt", 80'(zero_cnt), 80'(15));
        out_ready = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clrhs_cnt", 80'(zero_cnt), 80'(4));

        // Reset with two beats in flight.
        in_mode = 2'd0; in_valid = 1'b1; in_data = pack(1, 2, 3, 4);
        tick();
        in_data = pack(5, 6, 7, 8);
        tick();
        in_valid = 1'b0;
        chk("mid_pre_valid", 80'(out_valid), 80'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_async_valid", 80'(out_valid), 80'(0));
        chk("mid_async_cnt", 80'(zero_cnt), 80'(0));
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_no_stale_%0d", k), 80'(out_valid), 80'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
